// File: rtl/dfjk_event_reporter.sv
// DFJK key edge timestamper: per-lane pending slots feeding a show-ahead
// event FIFO that software drains through a pop-on-rising-ack handshake.
module dfjk_event_reporter #(
    parameter int TICK_DIV = 50,
    parameter int DEPTH    = 8
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [3:0]               DFJK,
    input  logic                     evt_ack,
    input  logic                     clr_overflow,
    output logic [31:0]              evt_data,
    output logic                     evt_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [15:0]   pre;
    logic [27:0]   ts;
    logic          tick;
    logic [3:0]    dfjk_q;
    logic [3:0]    edges;
    logic [3:0]    slot_v;
    logic [3:0]    slot_p;
    logic [27:0]   slot_ts [4];
    logic          ack_q;

    logic          push_req;
    logic [1:0]    sel;
    logic [3:0]    clr_mask;
    logic [3:0]    occupied;
    logic [3:0]    load;
    logic          slot_drop;
    logic [31:0]   push_data;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr_n;
    logic          pop;
    logic          full;
    logic          push_ok;
    logic          fifo_drop;
    logic [CW-1:0] count_n;
    logic [CW-1:0] remain;
    logic [31:0]   head_n;

    assign tick  = (pre == 16'(TICK_DIV - 1));
    assign edges = DFJK ^ dfjk_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pre    <= '0;
            ts     <= '0;
            dfjk_q <= '0;
            ack_q  <= 1'b0;
        end else begin
            pre    <= tick ? 16'd0 : pre + 16'd1;
            ts     <= ts + 28'(tick);
            dfjk_q <= DFJK;
            ack_q  <= evt_ack;
        end
    end

    // A slot being drained this cycle counts as free, so it can reload at once.
    always_comb begin
        push_req = |slot_v;
        sel      = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (slot_v[i]) sel = 2'(i);
        end
        clr_mask  = push_req ? (4'b0001 << sel) : 4'b0000;
        occupied  = slot_v & ~clr_mask;
        load      = edges & ~occupied;
        slot_drop = |(edges & occupied);
        push_data = {1'b0, slot_p[sel], sel, slot_ts[sel]};
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            slot_v <= '0;
            slot_p <= '0;
            for (int i = 0; i < 4; i++) slot_ts[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (load[i]) begin
                    slot_v[i]  <= 1'b1;
                    slot_p[i]  <= DFJK[i];
                    slot_ts[i] <= ts;
                end else if (clr_mask[i]) begin
                    slot_v[i]  <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        pop       = evt_ack & ~ack_q & (count != '0);
        full      = (count == CW'(DEPTH));
        push_ok   = push_req & (~full | pop);
        fifo_drop = push_req & full & ~pop;
        count_n   = count + CW'(push_ok) - CW'(pop);
        remain    = count - CW'(pop);
        rd_ptr_n  = rd_ptr + AW'(pop);
        head_n    = '0;
        if (count_n != '0)
            head_n = (remain == '0) ? push_data : mem[rd_ptr_n];
    end

    always_ff @(posedge Clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    // Head is re-registered every cycle so the PIO never samples a RAM glitch.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            evt_valid <= 1'b0;
            evt_data  <= '0;
            overflow  <= 1'b0;
        end else begin
            rd_ptr    <= rd_ptr_n;
            wr_ptr    <= wr_ptr + AW'(push_ok);
            count     <= count_n;
            evt_valid <= (count_n != '0);
            evt_data  <= head_n;
            if (slot_drop | fifo_drop)
                overflow <= 1'b1;
            else if (clr_overflow)
                overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dfjk_event_reporter.sv
// Directed bench for dfjk_event_reporter: vector table plus hand sequences
// for timestamp prescale, overflow, ack handshake and mid-run reset.
module tb_dfjk_event_reporter;

    logic        Clk;
    logic        Reset;
    logic [3:0]  f_dfjk, s_dfjk;
    logic        f_ack, s_ack, f_clr, s_clr;
    logic [31:0] f_data, s_data;
    logic        f_valid, s_valid, f_ovf, s_ovf;
    logic [3:0]  f_count, s_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [3:0]  dfjk;
        logic        ack;
        logic        clr;
        logic        valid;
        logic [3:0]  cnt;
        logic [31:0] data;
        logic        chk_data;
        logic        ovf;
    } vec_t;

    vec_t tbl[$];

    dfjk_event_reporter #(.TICK_DIV(1), .DEPTH(8)) u_fast (
        .Clk(Clk), .Reset(Reset), .DFJK(f_dfjk), .evt_ack(f_ack),
        .clr_overflow(f_clr), .evt_data(f_data), .evt_valid(f_valid),
        .count(f_count), .overflow(f_ovf)
    );

    dfjk_event_reporter #(.TICK_DIV(50), .DEPTH(8)) u_slow (
        .Clk(Clk), .Reset(Reset), .DFJK(s_dfjk), .evt_ack(s_ack),
        .clr_overflow(s_clr), .evt_data(s_data), .evt_valid(s_valid),
        .count(s_count), .overflow(s_ovf)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge Clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] d, input logic a, input logic c,
                       input logic v, input logic [3:0] n,
                       input logic [31:0] x, input logic cd);
        vec_t r;
        r.dfjk = d; r.ack = a; r.clr = c; r.valid = v;
        r.cnt = n; r.data = x; r.chk_data = cd; r.ovf = 1'b0;
        tbl.push_back(r);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        repeat (3) step();
        Reset = 1'b0;
        cyc = 0;
    endtask

    logic [27:0] st1;

    initial begin
        for (int i = 0; i < 5; i++) add(4'h0, 0, 0, 0, 0, 32'h0, 1);
        add(4'h1, 0, 0, 0, 0, 32'h0, 1);
        add(4'h1, 0, 0, 1, 1, 32'h4000_0005, 1);
        add(4'h1, 1, 0, 0, 0, 32'h0, 0);
        add(4'h0, 0, 0, 0, 0, 32'h0, 0);
        add(4'h0, 0, 0, 1, 1, 32'h0000_0008, 1);
        add(4'h0, 1, 0, 0, 0, 32'h0, 0);
        add(4'hF, 0, 0, 0, 0, 32'h0, 0);
        add(4'hF, 0, 0, 1, 1, 32'h4000_000B, 1);
        add(4'hF, 0, 0, 1, 2, 32'h4000_000B, 1);
        add(4'hF, 0, 0, 1, 3, 32'h4000_000B, 1);
        add(4'hF, 0, 0, 1, 4, 32'h4000_000B, 1);
        for (int i = 0; i < 10; i++) add(4'hF, 1, 0, 1, 3, 32'h5000_000B, 1);
        add(4'hF, 0, 0, 1, 3, 32'h5000_000B, 1);
        add(4'hF, 1, 0, 1, 2, 32'h6000_000B, 1);
        add(4'hF, 0, 0, 1, 2, 32'h6000_000B, 1);
        add(4'hF, 1, 0, 1, 1, 32'h7000_000B, 1);
        add(4'hF, 0, 0, 1, 1, 32'h7000_000B, 1);
        add(4'hF, 1, 0, 0, 0, 32'h0, 0);
        add(4'hF, 0, 0, 0, 0, 32'h0, 0);

        Reset = 1'b1;
        f_dfjk = 4'h0; s_dfjk = 4'h0;
        f_ack = 0; s_ack = 0; f_clr = 0; s_clr = 0;

        // reset state
        repeat (3) step();
        chk("rst_valid", {31'b0, f_valid}, 32'h0);
        chk("rst_count", {28'b0, f_count}, 32'h0);
        chk("rst_data", f_data, 32'h0);
        chk("rst_ovf", {31'b0, f_ovf}, 32'h0);
        chk("rst_slow_valid", {31'b0, s_valid}, 32'h0);
        Reset = 1'b0;
        cyc = 0;

        // prescaled timestamp: ts becomes 1 at edge 50
        repeat (49) step();
        s_dfjk = 4'h1;
        step();
        s_dfjk = 4'h3;
        step();
        step();
        chk("slow_count", {28'b0, s_count}, 32'd2);
        chk("slow_head0", s_data, 32'h4000_0000);
        s_ack = 1'b1;
        step();
        s_ack = 1'b0;
        chk("slow_head1", s_data, 32'h5000_0001);
        chk("slow_count1", {28'b0, s_count}, 32'd1);
        s_dfjk = 4'h0;

        // vector table
        do_reset();
        for (int r = 0; r < tbl.size(); r++) begin
            f_dfjk = tbl[r].dfjk;
            f_ack  = tbl[r].ack;
            f_clr  = tbl[r].clr;
            step();
            chk($sformatf("row%0d_valid", r), {31'b0, f_valid},
                {31'b0, tbl[r].valid});
            chk($sformatf("row%0d_count", r), {28'b0, f_count},
                {28'b0, tbl[r].cnt});
            if (tbl[r].chk_data)
                chk($sformatf("row%0d_data", r), f_data, tbl[r].data);
            chk($sformatf("row%0d_ovf", r), {31'b0, f_ovf},
                {31'b0, tbl[r].ovf});
        end

        // fill past full: 9 lane-0 edges, no ack
        f_ack = 1'b0;
        st1 = 28'(cyc);
        for (int i = 0; i < 9; i++) begin
            f_dfjk[0] = ~f_dfjk[0];
            step();
        end
        chk("full_count", {28'b0, f_count}, 32'd8);
        chk("full_ovf_pre", {31'b0, f_ovf}, 32'h0);
        step();
        chk("ovf_count", {28'b0, f_count}, 32'd8);
        chk("ovf_set", {31'b0, f_ovf}, 32'h1);
        chk("ovf_head", f_data, {4'h0, st1});
        f_clr = 1'b1;
        step();
        f_clr = 1'b0;
        chk("ovf_clr", {31'b0, f_ovf}, 32'h0);

        // push and pop together while full
        f_dfjk[0] = ~f_dfjk[0];
        step();
        f_ack = 1'b1;
        step();
        f_ack = 1'b0;
        chk("pp_count", {28'b0, f_count}, 32'd8);
        chk("pp_ovf", {31'b0, f_ovf}, 32'h0);
        chk("pp_head", f_data, {4'h4, st1 + 28'd1});

        // drop coinciding with clear: set wins
        f_dfjk[0] = ~f_dfjk[0];
        f_clr = 1'b1;
        step();
        step();
        chk("setwin_ovf", {31'b0, f_ovf}, 32'h1);
        f_clr = 1'b0;

        // reset with 3 queued and 1 pending
        f_dfjk = 4'h0;
        do_reset();
        step();
        step();
        f_dfjk = 4'hF;
        repeat (4) step();
        chk("mid_count", {28'b0, f_count}, 32'd3);
        Reset = 1'b1;
        f_dfjk = 4'h4;
        #1;
        chk("mid_valid", {31'b0, f_valid}, 32'h0);
        chk("mid_cnt0", {28'b0, f_count}, 32'h0);
        step();
        step();
        Reset = 1'b0;
        cyc = 0;
        step();
        step();
        chk("held_head", f_data, 32'h6000_0000);
        chk("held_count", {28'b0, f_count}, 32'd1);
        repeat (3) step();
        chk("held_once", {28'b0, f_count}, 32'd1);

        // edge on a slot that is still waiting
        f_dfjk = 4'hF;
        step();
        f_dfjk = 4'h7;
        step();
        chk("occ_ovf", {31'b0, f_ovf}, 32'h1);
        repeat (3) step();
        chk("occ_count", {28'b0, f_count}, 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
